mem_lane_align: RTL

//  Sequential load/store lane aligner between the MEM stage and word-wide data memory.

---
 rtl/mem_lane_align_if.sv | 43 ++++
 rtl/mem_lane_align.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_lane_align_if.sv
// Request/memory/response bundle for mem_lane_align.
// MEM_ALIGN_BE_EN adds the mem_be byte-enable signal.
interface mem_lane_align_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_opcode;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_valid;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_misalign;
    logic              resp_illegal;
`ifdef MEM_ALIGN_BE_EN
    logic [DATA_W/8-1:0] mem_be;
`endif

    modport master (
        output req_valid, req_opcode, req_addr, req_wdata, mem_rdata, mem_rdata_valid,
`ifdef MEM_ALIGN_BE_EN
        input  mem_be,
`endif
        input  req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
               resp_valid, resp_data, resp_misalign, resp_illegal
    );

    modport slave (
        input  req_valid, req_opcode, req_addr, req_wdata, mem_rdata, mem_rdata_valid,
`ifdef MEM_ALIGN_BE_EN
        output mem_be,
`endif
        output req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
               resp_valid, resp_data, resp_misalign, resp_illegal
    );
endinterface

// File: rtl/mem_lane_align.sv
// Load/store lane aligner: reads the containing word, extends loads, merges stores.
// MEM_ALIGN_BE_EN: stores write replicated data with byte enables instead of RMW.
module mem_lane_align_byte (
    input  logic       sel_i,
    input  logic [7:0] new_i,
    input  logic [7:0] old_i,
    output logic [7:0] byte_o
);
    assign byte_o = sel_i ? new_i : old_i;
endmodule

module mem_lane_align #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input logic            clk_i,
    input logic            rst_n_i,
    mem_lane_align_if.slave bus
);
    localparam int NB   = DATA_W / 8;
    localparam int LB_W = $clog2(NB);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, RESP} state_t;
    state_t state_q, state_d;

    logic              ready_q, st_q, uns_q, mis_q, ill_q;
    logic [1:0]        sz_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [DATA_W-1:0] resp_data_q;

    logic              dec_legal, dec_st, dec_uns, dec_mis, skip_rd, accept;
    logic [1:0]        dec_sz;
    logic [LB_W-1:0]   req_lane, lane_q;
    logic [DATA_W-1:0] rd_sh, ld_val, repl;
    logic [NB-1:0]     be;

    // sz encodes access width as log2(bytes)
    always_comb begin
        dec_legal = 1'b1;
        dec_st    = 1'b0;
        dec_sz    = 2'd0;
        dec_uns   = 1'b0;
        case (bus.req_opcode)
            6'b100000: ;
            6'b100001: dec_sz = 2'd1;
            6'b100011: dec_sz = 2'd2;
            6'b100100: dec_uns = 1'b1;
            6'b100101: begin dec_sz = 2'd1; dec_uns = 1'b1; end
            6'b101000: dec_st = 1'b1;
            6'b101001: begin dec_st = 1'b1; dec_sz = 2'd1; end
            6'b101011: begin dec_st = 1'b1; dec_sz = 2'd2; end
            default:   dec_legal = 1'b0;
        endcase
    end

    assign req_lane = bus.req_addr[LB_W-1:0];
    assign dec_mis  = dec_legal && ((dec_sz == 2'd1 && req_lane[0]) ||
                                    (dec_sz == 2'd2 && req_lane[1:0] != 2'b00));
`ifdef MEM_ALIGN_BE_EN
    assign skip_rd  = dec_st;
`else
    assign skip_rd  = dec_st && dec_sz == 2'd2 && DATA_W == 32;
`endif
    assign accept   = bus.req_valid && ready_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) begin
                         if (!dec_legal || dec_mis) state_d = RESP;
                         else if (skip_rd)          state_d = WR;
                         else                       state_d = RD_REQ;
                     end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: if (bus.mem_rdata_valid) state_d = st_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign lane_q = addr_q[LB_W-1:0];
    assign rd_sh  = bus.mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (sz_q)
            2'd0:    ld_val = uns_q ? DATA_W'(rd_sh[7:0])  : DATA_W'($signed(rd_sh[7:0]));
            2'd1:    ld_val = uns_q ? DATA_W'(rd_sh[15:0]) : DATA_W'($signed(rd_sh[15:0]));
            default: ld_val = DATA_W'($signed(rd_sh[31:0]));
        endcase
    end

`ifndef MEM_ALIGN_BE_EN
    logic [DATA_W-1:0] rdata_q, merged;
`endif

    // Store data is replicated across the word so each lane picks its own slice;
    // alignment is guaranteed because misaligned requests never reach WR.
    for (genvar b = 0; b < NB; b++) begin : g_lane
        assign repl[8*b +: 8] = (sz_q == 2'd0) ? wdata_q[7:0] :
                                (sz_q == 2'd1) ? wdata_q[8*(b%2) +: 8] : wdata_q[8*(b%4) +: 8];
        assign be[b] = (sz_q == 2'd0) ? (32'(lane_q) == 32'(b)) :
                       (sz_q == 2'd1) ? ((32'(lane_q) >> 1) == 32'(b/2)) :
                                        ((32'(lane_q) >> 2) == 32'(b/4));
`ifndef MEM_ALIGN_BE_EN
        mem_lane_align_byte u_byte (
            .sel_i (be[b]),
            .new_i (repl[8*b +: 8]),
            .old_i (rdata_q[8*b +: 8]),
            .byte_o(merged[8*b +: 8])
        );
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            st_q        <= 1'b0;
            uns_q       <= 1'b0;
            sz_q        <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            mis_q       <= 1'b0;
            ill_q       <= 1'b0;
`ifndef MEM_ALIGN_BE_EN
            rdata_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata[31:0];
                st_q    <= dec_st;
                sz_q    <= dec_sz;
                uns_q   <= dec_uns;
                if (!dec_legal || dec_mis) begin
                    resp_data_q <= '0;
                    mis_q       <= dec_mis;
                    ill_q       <= !dec_legal;
                end
            end
            if (state_q == RD_WAIT && bus.mem_rdata_valid) begin
`ifndef MEM_ALIGN_BE_EN
                rdata_q <= bus.mem_rdata;
`endif
                if (!st_q) begin
                    resp_data_q <= ld_val;
                    mis_q       <= 1'b0;
                    ill_q       <= 1'b0;
                end
            end
            if (state_q == WR) begin
                resp_data_q <= '0;
                mis_q       <= 1'b0;
                ill_q       <= 1'b0;
            end
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.mem_rd_en     = (state_q == RD_REQ);
    assign bus.mem_wr_en     = (state_q == WR);
    assign bus.mem_addr      = {addr_q[ADDR_W-1:LB_W], {LB_W{1'b0}}};
    assign bus.resp_valid    = (state_q == RESP);
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_misalign = mis_q;
    assign bus.resp_illegal  = ill_q;
`ifdef MEM_ALIGN_BE_EN
    assign bus.mem_wdata     = repl;
    assign bus.mem_be        = (state_q == WR) ? be : '0;
`else
    assign bus.mem_wdata     = merged;
`endif
endmodule
